// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the UART command scheduler.
package uart_cmd_pkg;

    localparam logic [7:0] OP_INIT   = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] TERM_BYTE = 8'h00;

    typedef enum logic [1:0] {
        P_LENH,
        P_LENL,
        P_PAY,
        P_TERM
    } parse_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_REQ,
        D_WAIT
    } disp_state_t;

endpackage

// File: rtl/uart_cmd_sched_sd_dispatch.sv
// SD request/acknowledge/done sequencing plus the card-ready flag and block address.
module sd_dispatch
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  logic              launch_read,
    input  logic              sd_ack,
    input  logic              sd_done,
    input  logic              sd_err,
    output logic              sd_init_req,
    output logic              sd_rd_req,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_ready,
    output logic              busy
);

    disp_state_t state;
    logic        is_read;
    logic        finish;

    // Ack and done in the same cycle completes straight from D_REQ.
    always_comb begin
        finish = 1'b0;
        if (state == D_WAIT && sd_done) finish = 1'b1;
        if (state == D_REQ && sd_ack && sd_done) finish = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= D_IDLE;
            is_read     <= 1'b0;
            sd_init_req <= 1'b0;
            sd_rd_req   <= 1'b0;
            sd_addr     <= '0;
            sd_ready    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                D_IDLE: begin
                    if (launch) begin
                        state       <= D_REQ;
                        busy        <= 1'b1;
                        is_read     <= launch_read;
                        sd_init_req <= !launch_read;
                        sd_rd_req   <= launch_read;
                    end
                end
                D_REQ: begin
                    if (sd_ack) begin
                        sd_init_req <= 1'b0;
                        sd_rd_req   <= 1'b0;
                        state       <= D_WAIT;
                    end
                end
                D_WAIT: ;
                default: state <= D_IDLE;
            endcase

            if (finish) begin
                state <= D_IDLE;
                busy  <= 1'b0;
                if (is_read) begin
                    if (!sd_err) sd_addr <= sd_addr + 1'b1;
                end else begin
                    sd_ready <= !sd_err;
                    sd_addr  <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/uart_cmd_sched.sv
// Length-framed UART byte parser: feeds data payloads to the write FIFO and
// turns one-byte command frames into SD init/read requests.
module uart_cmd_sched
    import uart_cmd_pkg::*;
#(
    parameter int unsigned GAP_TIMEOUT = 200000,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_vld,
    output logic              fifo_wr_en,
    output logic [7:0]        fifo_wr_data,
    input  logic              fifo_full,
    output logic              sd_init_req,
    output logic              sd_rd_req,
    output logic [ADDR_W-1:0] sd_addr,
    input  logic              sd_ack,
    input  logic              sd_done,
    input  logic              sd_err,
    output logic              sd_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              cmd_err
);

    localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

    parse_state_t     state;
    logic [7:0]       len_hi;
    logic [15:0]      cnt;
    logic             is_cmd;
    logic [7:0]       opcode;
    logic             overflow;
    logic [GAP_W-1:0] gap_cnt;

    logic term_ok;
    logic cmd_ok;
    logic launch;
    logic timeout;

    always_comb begin
        term_ok = rx_vld && (state == P_TERM) && (rx_data == TERM_BYTE) && !overflow;
        cmd_ok  = ((opcode == OP_INIT) || (opcode == OP_READ)) && !busy
                  && !((opcode == OP_READ) && !sd_ready);
        launch  = term_ok && is_cmd && cmd_ok;
        timeout = (state != P_LENH) && !rx_vld && (gap_cnt == GAP_W'(GAP_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= P_LENH;
            len_hi       <= '0;
            cnt          <= '0;
            is_cmd       <= 1'b0;
            opcode       <= '0;
            overflow     <= 1'b0;
            gap_cnt      <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_err    <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            frame_err  <= 1'b0;
            cmd_err    <= 1'b0;

            if (state == P_LENH || rx_vld) gap_cnt <= '0;
            else                           gap_cnt <= gap_cnt + 1'b1;

            if (timeout) begin
                frame_err <= 1'b1;
                state     <= P_LENH;
            end else if (rx_vld) begin
                case (state)
                    P_LENH: begin
                        len_hi   <= rx_data;
                        overflow <= 1'b0;
                        state    <= P_LENL;
                    end
                    P_LENL: begin
                        cnt    <= {len_hi, rx_data};
                        is_cmd <= ({len_hi, rx_data} == 16'd1);
                        state  <= ({len_hi, rx_data} == 16'd0) ? P_TERM : P_PAY;
                    end
                    P_PAY: begin
                        if (is_cmd) begin
                            opcode <= rx_data;
                        end else if (!fifo_full) begin
                            fifo_wr_en   <= 1'b1;
                            fifo_wr_data <= rx_data;
                        end else begin
                            overflow <= 1'b1;
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == 16'd1) state <= P_TERM;
                    end
                    P_TERM: begin
                        if (!term_ok)              frame_err <= 1'b1;
                        else if (is_cmd && !cmd_ok) cmd_err  <= 1'b1;
                        state <= P_LENH;
                    end
                    default: state <= P_LENH;
                endcase
            end
        end
    end

    sd_dispatch #(
        .ADDR_W(ADDR_W)
    ) u_dispatch (
        .clk        (clk),
        .rst_n      (rst_n),
        .launch     (launch),
        .launch_read(opcode == OP_READ),
        .sd_ack     (sd_ack),
        .sd_done    (sd_done),
        .sd_err     (sd_err),
        .sd_init_req(sd_init_req),
        .sd_rd_req  (sd_rd_req),
        .sd_addr    (sd_addr),
        .sd_ready   (sd_ready),
        .busy       (busy)
    );

endmodule
